// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding, price table and timer sizing for the vending controller
package vm_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_KEY, CHECK, WAIT_TRAN, WAIT_OPEN, WAIT_CLOSE} vm_state_e;
  function automatic int vm_tmr_w(int timeout);
    return timeout < 2 ? 1 : $clog2(timeout);
  endfunction
  function automatic int vm_price(int code, int cost_max);
    int p;
    p = code < 16 ? code / 4 + 1 : code < 18 ? 5 : 6;
    return p > cost_max ? cost_max : p;
  endfunction
endpackage

// File: rtl/vm_stock_bank.sv
// vm_stock_bank: per-slot stock counters with bulk reload and saturating decrement
module vm_stock_bank #(
  parameter int NUM_ITEMS  = 20,
  parameter int CODE_W     = 5,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_QTY = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              reload_i,
  input  logic              dec_en_i,
  input  logic [CODE_W-1:0] dec_idx_i,
  input  logic [CODE_W-1:0] rd_idx_i,
  output logic              rd_empty_o
);
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (RESET) stock_q[i] <= '0;
      else if (reload_i) stock_q[i] <= STOCK_W'(RELOAD_QTY);
      else if (dec_en_i && dec_idx_i == CODE_W'(i) && stock_q[i] != '0) stock_q[i] <= stock_q[i] - 1'b1;
    end
  end
  // out-of-range slots read as empty
  always_comb begin
    rd_empty_o = 1'b1;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (rd_idx_i == CODE_W'(i)) rd_empty_o = stock_q[i] == '0;
  end
endmodule

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: card-payment vending FSM with stock tracking, tiered pricing and state timeouts
module vend_ctrl_multi
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 20,
  parameter int CODE_W     = 5,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_QTY = 10,
  parameter int COST_W     = 3,
  parameter int TIMEOUT    = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CARD_IN,
  input  logic              KEY_PRESS,
  input  logic [CODE_W-1:0] ITEM_CODE,
  input  logic              VALID_TRAN,
  input  logic              DOOR_OPEN,
  input  logic              RELOAD,
  output logic              VEND,
  output logic              INVALID_SEL,
  output logic              SOLD_OUT,
  output logic              FAILED_TRAN,
  output logic [COST_W-1:0] COST
);
  localparam int TW = vm_tmr_w(TIMEOUT);
  vm_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [COST_W-1:0] cost_q, cost_d;
  logic kp_q, vend_q, vend_d, inv_q, inv_d, so_q, so_d, ft_q, ft_d;
  logic reload, dec_en, rd_empty, key_edge, tmo;
  vm_stock_bank #(.NUM_ITEMS(NUM_ITEMS), .CODE_W(CODE_W), .STOCK_W(STOCK_W), .RELOAD_QTY(RELOAD_QTY)) u_bank (
    .CLK(CLK), .RESET(RESET), .reload_i(reload), .dec_en_i(dec_en),
    .dec_idx_i(code_q), .rd_idx_i(code_q), .rd_empty_o(rd_empty)
  );
  assign key_edge = KEY_PRESS & ~kp_q;
  assign tmo = timer_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    cost_d = cost_q;
    inv_d = inv_q;
    so_d = so_q;
    ft_d = ft_q;
    reload = 1'b0;
    dec_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (RELOAD) reload = 1'b1;
        else if (CARD_IN) begin
          {inv_d, so_d, ft_d} = '0;
          state_d = WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        if (key_edge) begin
          code_d = ITEM_CODE;
          state_d = CHECK;
        end else if (tmo) state_d = IDLE;
      end
      CHECK: begin
        if (int'(code_q) >= NUM_ITEMS) begin
          inv_d = 1'b1;
          state_d = IDLE;
        end else if (rd_empty) begin
          so_d = 1'b1;
          state_d = IDLE;
        end else begin
          cost_d = COST_W'(vm_price(int'(code_q), 2 ** COST_W - 1));
          state_d = WAIT_TRAN;
        end
      end
      WAIT_TRAN: begin
        if (VALID_TRAN) begin
          dec_en = 1'b1;
          state_d = WAIT_OPEN;
        end else if (tmo) begin
          ft_d = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_OPEN: state_d = DOOR_OPEN ? WAIT_CLOSE : tmo ? IDLE : WAIT_OPEN;
      WAIT_CLOSE: state_d = DOOR_OPEN ? WAIT_CLOSE : IDLE;
      default: state_d = IDLE;
    endcase
    cost_d = state_d == IDLE ? '0 : cost_d;
    vend_d = state_d == WAIT_OPEN || state_d == WAIT_CLOSE;
    timer_d = state_d != state_q ? '0 : tmo ? timer_q : timer_q + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      timer_q <= '0;
      code_q <= '0;
      cost_q <= '0;
      {kp_q, vend_q, inv_q, so_q, ft_q} <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q <= code_d;
      cost_q <= cost_d;
      kp_q <= KEY_PRESS;
      vend_q <= vend_d;
      inv_q <= inv_d;
      so_q <= so_d;
      ft_q <= ft_d;
    end
  end
  assign VEND = vend_q;
  assign INVALID_SEL = inv_q;
  assign SOLD_OUT = so_q;
  assign FAILED_TRAN = ft_q;
  assign COST = cost_q;
endmodule
